// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: stage indices, default request map,
// FSM state encoding.
package pipe_hazard_ctrl_pkg;

    localparam int STG_W = 3;
    localparam int PC_W  = 32;

    localparam logic [STG_W-1:0] STG_PC  = 3'd0;
    localparam logic [STG_W-1:0] STG_IF  = 3'd1;
    localparam logic [STG_W-1:0] STG_ID  = 3'd2;
    localparam logic [STG_W-1:0] STG_EX  = 3'd3;
    localparam logic [STG_W-1:0] STG_MEM = 3'd4;
    localparam logic [STG_W-1:0] STG_WB  = 3'd5;

    localparam int STAGES_DEF    = int'(STG_WB) + 1;
    localparam int NREQ_DEF      = 3;
    localparam int DRAIN_STG_DEF = int'(STG_MEM);
    localparam int MAX_STALL_DEF = 1024;
    localparam int CNT_W_DEF     = 32;

    // Request i lives in slice [3i +: 3]: req0=ID (load-use), req1=EX (div), req2=MEM (dsram)
    localparam logic [NREQ_DEF*STG_W-1:0] REQ_STAGE_DEF = {STG_MEM, STG_EX, STG_ID};

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline top and the hazard controller: stall requests and
// exception in, stall bus, redirect and statistics out.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int CNT_W  = CNT_W_DEF
);

    logic [NREQ-1:0]   stall_req;
    logic              excp_valid;
    logic [PC_W-1:0]   excp_pc;
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [PC_W-1:0]   new_pc;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;
    logic              timeout;

    modport master (
        output stall_req, excp_valid, excp_pc,
        input  stall, flush, new_pc, stall_cycles, flush_count, timeout
    );

    modport slave (
        input  stall_req, excp_valid, excp_pc,
        output stall, flush, new_pc, stall_cycles, flush_count, timeout
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Free-running event counter: increments on each enabled cycle, wraps modulo 2^CNT_W.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges stall requests into a per-stage stall bus,
// sequences exception flushes behind draining memory accesses, and runs a stall watchdog.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int                      STAGES    = STAGES_DEF,
    parameter int                      NREQ      = NREQ_DEF,
    parameter logic [NREQ*STG_W-1:0]   REQ_STAGE = REQ_STAGE_DEF,
    parameter int                      DRAIN_STG = DRAIN_STG_DEF,
    parameter int                      MAX_STALL = MAX_STALL_DEF,
    parameter int                      CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int                RUN_W   = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL - 1);

    logic [STG_W-1:0]  req_stage [NREQ];
    logic [NREQ-1:0]   req_at_drain;
    logic              drain_busy;
    logic [STG_W-1:0]  max_stage;
    logic              any_req;
    logic              stall_gate;
    logic [STAGES-1:0] stall_bus;
    logic              stall_any;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next;
    logic              flush_reg;
    logic [PC_W-1:0]   new_pc_reg;
    logic [RUN_W-1:0]  run_reg;
    logic              timeout_reg;

    // ---------------------------------------------------------------- stall merge
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_stage[gi]    = REQ_STAGE[gi*STG_W +: STG_W];
            assign req_at_drain[gi] = hz.stall_req[gi] && (int'(req_stage[gi]) >= DRAIN_STG);
        end
    endgenerate

    assign drain_busy = |req_at_drain;

    always_comb begin
        max_stage = STG_PC;
        any_req   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (hz.stall_req[i]) begin
                any_req = 1'b1;
                if (req_stage[i] > max_stage) begin
                    max_stage = req_stage[i];
                end
            end
        end
    end

    // Flush owns the pipeline for its cycle, so every request is masked then.
    assign stall_gate = any_req && !rst && (state_reg != ST_FLUSH);

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stall
            assign stall_bus[gi] = stall_gate && (gi <= int'(max_stage));
        end
    endgenerate

    assign stall_any = |stall_bus;

    // ---------------------------------------------------------------- flush FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            pc_reg     <= '0;
            flush_reg  <= 1'b0;
            new_pc_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            flush_reg  <= (state_next == ST_FLUSH);
            new_pc_reg <= (state_next == ST_FLUSH) ? pc_next : '0;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        unique case (state_reg)
            ST_RUN: begin
                // Only RUN accepts an exception, so the first one wins until the flush retires.
                if (hz.excp_valid) begin
                    pc_next    = hz.excp_pc;
                    state_next = drain_busy ? ST_FLUSH_WAIT : ST_FLUSH;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!drain_busy) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------- watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            run_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (!stall_any) begin
                run_reg <= '0;
            end else if (run_reg != RUN_MAX) begin
                run_reg <= run_reg + RUN_W'(1);
            end
            if (stall_any && (run_reg == RUN_MAX)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- counters
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .srst  (rst),
        .en    (stall_any),
        .count (hz.stall_cycles)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .srst  (rst),
        .en    (flush_reg),
        .count (hz.flush_count)
    );

    assign hz.stall   = stall_bus;
    assign hz.flush   = flush_reg;
    assign hz.new_pc  = new_pc_reg;
    assign hz.timeout = timeout_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of stall merge, flush sequencing and watchdog.
module tb_pipe_hazard_ctrl;

    localparam int MAX_STALL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.NREQ(3), .STAGES(6), .CNT_W(32)) hz ();

    pipe_hazard_ctrl #(.MAX_STALL(MAX_STALL)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Stage each request source sits in: ID, EX, MEM
    int req_stg [3] = '{2, 3, 4};

    // Model state: values the registered outputs should hold after the last edge
    bit          model_valid = 1'b0;
    bit          m_flush;
    logic [31:0] m_new_pc;
    logic [31:0] m_stall_cycles;
    logic [31:0] m_flush_count;
    bit          m_timeout;
    int          m_run;
    bit          m_pending;
    logic [31:0] m_pend_pc;

    // Snapshot of DUT outputs taken during the most recent step
    logic [5:0]  obs_stall;
    logic        obs_flush;
    logic [31:0] obs_new_pc;
    logic [31:0] obs_stall_cycles;
    logic [31:0] obs_flush_count;
    logic        obs_timeout;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] merge_model(input logic [2:0] req);
        int top = -1;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && req_stg[i] > top) top = req_stg[i];
        end
        return (top < 0) ? 6'd0 : 6'((1 << (top + 1)) - 1);
    endfunction

    function automatic bit drain_model(input logic [2:0] req);
        bit d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (req[i] && req_stg[i] >= 4) d = 1'b1;
        end
        return d;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input bit r, input logic [2:0] req, input bit ev, input logic [31:0] pc);
        logic [5:0] es;
        bit         nf;
        @(negedge clk);
        rst           = r;
        hz.stall_req  = req;
        hz.excp_valid = ev;
        hz.excp_pc    = pc;
        #1;
        obs_stall        = hz.stall;
        obs_flush        = hz.flush;
        obs_new_pc       = hz.new_pc;
        obs_stall_cycles = hz.stall_cycles;
        obs_flush_count  = hz.flush_count;
        obs_timeout      = hz.timeout;

        es = (r || m_flush) ? 6'd0 : merge_model(req);
        check_val("stall", {26'd0, obs_stall}, {26'd0, es});
        if (model_valid) begin
            check_val("flush", {31'd0, obs_flush}, {31'd0, m_flush});
            if (m_flush) check_val("new_pc", obs_new_pc, m_new_pc);
            check_val("stall_cycles", obs_stall_cycles, m_stall_cycles);
            check_val("flush_count", obs_flush_count, m_flush_count);
            check_val("timeout", {31'd0, obs_timeout}, {31'd0, m_timeout});
        end

        @(posedge clk);
        if (r) begin
            model_valid    = 1'b1;
            m_flush        = 1'b0;
            m_new_pc       = '0;
            m_stall_cycles = '0;
            m_flush_count  = '0;
            m_timeout      = 1'b0;
            m_run          = 0;
            m_pending      = 1'b0;
            m_pend_pc      = '0;
        end else begin
            if (es != 0) m_stall_cycles = m_stall_cycles + 32'd1;
            if (m_flush) m_flush_count = m_flush_count + 32'd1;
            if (es != 0) begin
                if (m_run < MAX_STALL) m_run++;
                if (m_run >= MAX_STALL) m_timeout = 1'b1;
            end else begin
                m_run = 0;
            end
            nf = 1'b0;
            if (m_pending) begin
                if (!drain_model(req)) begin
                    nf        = 1'b1;
                    m_new_pc  = m_pend_pc;
                    m_pending = 1'b0;
                end
            end else if (!m_flush && ev) begin
                if (drain_model(req)) begin
                    m_pending = 1'b1;
                    m_pend_pc = pc;
                end else begin
                    nf       = 1'b1;
                    m_new_pc = pc;
                end
            end
            m_flush = nf;
        end
    endtask

    initial begin
        hz.stall_req  = '0;
        hz.excp_valid = 1'b0;
        hz.excp_pc    = '0;

        // T1: reset with random requests
        for (int i = 0; i < 3; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 32'd0);

        // T2: single ID request; reset values visible in the same step
        step(1'b0, 3'b001, 1'b0, 32'd0);
        check_val("t1_stall_cycles", obs_stall_cycles, 32'd0);
        check_val("t1_flush_count", obs_flush_count, 32'd0);
        check_val("t1_timeout", {31'd0, obs_timeout}, 32'd0);
        check_val("t1_flush", {31'd0, obs_flush}, 32'd0);
        check_val("t1_new_pc", obs_new_pc, 32'd0);
        check_val("t2_stall", {26'd0, obs_stall}, 32'b000111);
        step(1'b0, 3'b000, 1'b0, 32'd0);
        check_val("t2_stall_off", {26'd0, obs_stall}, 32'd0);
        check_val("t2_stall_cycles", obs_stall_cycles, 32'd1);

        // T3: highest stage wins
        step(1'b0, 3'b011, 1'b0, 32'd0);
        check_val("t3_stall_ex", {26'd0, obs_stall}, 32'b001111);
        step(1'b0, 3'b100, 1'b0, 32'd0);
        check_val("t3_stall_mem", {26'd0, obs_stall}, 32'b011111);

        // T4: exception with no requests flushes next cycle
        step(1'b0, 3'b000, 1'b1, 32'hBFC00380);
        step(1'b0, 3'b000, 1'b0, 32'd0);
        check_val("t4_flush", {31'd0, obs_flush}, 32'd1);
        check_val("t4_new_pc", obs_new_pc, 32'hBFC00380);
        check_val("t4_stall", {26'd0, obs_stall}, 32'd0);
        step(1'b0, 3'b000, 1'b0, 32'd0);
        check_val("t4_flush_count", obs_flush_count, 32'd1);
        check_val("t4_flush_done", {31'd0, obs_flush}, 32'd0);

        // Flush overrides lower-stage requests
        step(1'b0, 3'b000, 1'b1, 32'h8000_0100);
        step(1'b0, 3'b011, 1'b0, 32'd0);
        check_val("ovr_flush", {31'd0, obs_flush}, 32'd1);
        check_val("ovr_stall", {26'd0, obs_stall}, 32'd0);

        // T5: MEM request drains before the flush; second exception ignored
        step(1'b0, 3'b100, 1'b0, 32'd0);
        step(1'b0, 3'b100, 1'b1, 32'h1111_2220);
        step(1'b0, 3'b100, 1'b1, 32'h3333_4440);
        check_val("t5_wait_noflush", {31'd0, obs_flush}, 32'd0);
        step(1'b0, 3'b100, 1'b0, 32'd0);
        check_val("t5_wait_stall", {26'd0, obs_stall}, 32'b011111);
        step(1'b0, 3'b000, 1'b0, 32'd0);
        check_val("t5_drop_noflush", {31'd0, obs_flush}, 32'd0);
        step(1'b0, 3'b000, 1'b0, 32'd0);
        check_val("t5_flush", {31'd0, obs_flush}, 32'd1);
        check_val("t5_new_pc", obs_new_pc, 32'h1111_2220);
        step(1'b0, 3'b000, 1'b0, 32'd0);
        check_val("t5_single_flush", {31'd0, obs_flush}, 32'd0);

        // T6: watchdog with MAX_STALL=8, EX request held 10 cycles
        step(1'b1, 3'b000, 1'b0, 32'd0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 3'b010, 1'b0, 32'd0);
            if (k == 7) check_val("t6_before", {31'd0, obs_timeout}, 32'd0);
            if (k == 8) check_val("t6_rise", {31'd0, obs_timeout}, 32'd1);
        end
        step(1'b0, 3'b000, 1'b0, 32'd0);
        step(1'b0, 3'b000, 1'b0, 32'd0);
        check_val("t6_sticky", {31'd0, obs_timeout}, 32'd1);

        // Randomized traffic with occasional reset
        step(1'b1, 3'b000, 1'b0, 32'd0);
        for (int i = 0; i < 600; i++) begin
            bit          r;
            logic [2:0]  req;
            bit          ev;
            logic [31:0] pc;
            r   = ($urandom_range(0, 59) == 0);
            req = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            ev  = ($urandom_range(0, 5) == 0);
            pc  = $urandom;
            step(r, req, ev, pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
